// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; samples mid-bit with a reloadable baud counter.
module uart_rx #(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q;
  logic            sync_q;
  logic            rxs_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   reload_q;
  logic [2:0]      bitcnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            rcv_q;
  logic            ferr_q;
  logic            tick;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= rx;
      rxs_q  <= sync_q;
    end
  end

  assign tick = (cnt_q == reload_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      rcv_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rcv_q  <= 1'b0;
      ferr_q <= 1'b0;

      // Counter is parked at zero whenever no sample point is pending.
      if (state_q == S_IDLE || state_q == S_BREAK || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            reload_q <= HALF_RELOAD;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (rxs_q) begin
              state_q <= S_IDLE;
            end else begin
              reload_q <= FULL_RELOAD;
              bitcnt_q <= 3'd0;
              state_q  <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q  <= {rxs_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (tick) begin
            if (rxs_q) begin
              data_q  <= shift_q;
              rcv_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data = data_q;
  assign rcv  = rcv_q;
  assign ferr = ferr_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed, table-driven bench for uart_rx at BAUD_DIV=8.
module tb_uart_rx;

  localparam int BD = 8;
  // Drive edge to visible rcv: 2 sync flops + half bit + 9 bits + 1 output register.
  localparam int LAT_EXP = 2 + BD / 2 + 9 * BD + 1;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  int errors;
  int checks;
  int cyc;
  int rcv_cnt;
  int ferr_cnt;
  int wide_cnt;
  int both_cnt;
  int last_rcv_cyc;
  int t_start;
  bit busy_seen;
  bit rcv_prev;
  bit ferr_prev;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .ferr (ferr),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rcv) begin
      rcv_cnt      = rcv_cnt + 1;
      last_rcv_cyc = cyc;
      if (rcv_prev) wide_cnt = wide_cnt + 1;
    end
    if (ferr) begin
      ferr_cnt = ferr_cnt + 1;
      if (ferr_prev) wide_cnt = wide_cnt + 1;
    end
    if (rcv && ferr) both_cnt = both_cnt + 1;
    if (busy) busy_seen = 1'b1;
    rcv_prev  = rcv;
    ferr_prev = ferr;
  end

  typedef struct {
    logic [7:0] din;
    int         gap;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rx      = 1'b0;
    t_start = cyc;
    idle(BD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BD);
    end
    rx = stop_v;
    idle(BD);
  endtask

  vec_t vecs[4];
  int   r0;
  int   f0;
  int   lat;

  initial begin
    vecs[0] = '{din: 8'h55, gap: 4};
    vecs[1] = '{din: 8'hA3, gap: 4};
    vecs[2] = '{din: 8'h00, gap: 0};
    vecs[3] = '{din: 8'hFF, gap: 4};

    errors = 0; checks = 0; cyc = 0;
    rcv_cnt = 0; ferr_cnt = 0; wide_cnt = 0; both_cnt = 0;
    last_rcv_cyc = 0; t_start = 0;
    busy_seen = 1'b0; rcv_prev = 1'b0; ferr_prev = 1'b0;

    rx   = 1'b1;
    rstn = 1'b0;
    idle(3);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_rcv",  {31'd0, rcv},  32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;

    busy_seen = 1'b0;
    idle(100);
    check("idle_rcv_cnt",  rcv_cnt,  32'd0);
    check("idle_ferr_cnt", ferr_cnt, 32'd0);
    check("idle_busy",     {31'd0, busy_seen}, 32'd0);
    check("idle_data",     {24'd0, data}, 32'h00);

    for (int v = 0; v < 4; v++) begin
      r0 = rcv_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[v].din, 1'b1);
      lat = last_rcv_cyc - t_start;
      check($sformatf("vec%0d_rcv", v),  rcv_cnt - r0, 32'd1);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, 32'd0);
      check($sformatf("vec%0d_data", v), {24'd0, data}, {24'd0, vecs[v].din});
      check($sformatf("vec%0d_lat_ok(lat=%0d)", v, lat),
            {31'd0, (lat >= LAT_EXP - 1) && (lat <= LAT_EXP + 1)}, 32'd1);
      rx = 1'b1;
      idle(vecs[v].gap);
      if (vecs[v].gap > 0) check($sformatf("vec%0d_busy_after", v), {31'd0, busy}, 32'd0);
    end

    // Glitch: too short to survive the start-bit check.
    r0 = rcv_cnt; f0 = ferr_cnt; busy_seen = 1'b0;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    check("glitch_busy_rose", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_now",  {31'd0, busy}, 32'd0);
    check("glitch_rcv",  rcv_cnt - r0, 32'd0);
    check("glitch_ferr", ferr_cnt - f0, 32'd0);

    // Framing error followed by a held-low line, then a good frame.
    r0 = rcv_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    idle(20);
    check("ferr_pulses", ferr_cnt - f0, 32'd1);
    check("ferr_no_rcv", rcv_cnt - r0, 32'd0);
    check("ferr_data_kept", {24'd0, data}, 32'hFF);
    check("ferr_busy_low_line", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    idle(6);
    check("break_exit_busy", {31'd0, busy}, 32'd0);
    r0 = rcv_cnt;
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    idle(4);
    check("after_break_rcv",  rcv_cnt - r0, 32'd1);
    check("after_break_data", {24'd0, data}, 32'h81);
    check("after_break_ferr", ferr_cnt - f0, 32'd1);

    // Reset asserted during data bit 4 of 0x99.
    r0 = rcv_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    idle(BD);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h99 >> i) & 8'h01;
      idle(BD);
    end
    rx = 1'b1;
    idle(BD / 2);
    rstn = 1'b0;
    idle(2);
    check("midreset_data", {24'd0, data}, 32'h00);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    idle(BD * 8);
    check("midreset_no_rcv",  rcv_cnt - r0, 32'd0);
    check("midreset_no_ferr", ferr_cnt - f0, 32'd0);
    send_frame(8'h12, 1'b1);
    rx = 1'b1;
    idle(4);
    check("post_reset_rcv",  rcv_cnt - r0, 32'd1);
    check("post_reset_data", {24'd0, data}, 32'h12);

    check("pulse_width_1", wide_cnt, 32'd0);
    check("rcv_ferr_excl", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
